// File: rtl/left_shift_unit_pkg.sv
// Shared definitions for the left shift unit: operand width, shift-amount
// width, FSM state encoding and the fixed number of shift stages.
package left_shift_unit_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned SHAMT_W     = 5;
  localparam int unsigned STAGE_CNT   = 5;
  localparam int unsigned STAGE_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/left_shift_unit_stage.sv
// One stage of the iterative left shifter. Shifts or rotates the accumulator
// left by 2^stage_i when en_i is set, otherwise passes it through.
// Ports:
//   acc_i    - current accumulator value
//   stage_i  - stage index k (0..SHAMT_W-1), shift distance is 2^k
//   en_i     - shift-amount bit k; 0 leaves the accumulator unchanged
//   rotate_i - 1 = rotate left, 0 = logical shift left with zero fill
//   acc_o    - next accumulator value
module left_shift_stage #(
  parameter int unsigned XLEN        = left_shift_unit_pkg::XLEN,
  parameter int unsigned SHAMT_W     = left_shift_unit_pkg::SHAMT_W,
  parameter int unsigned STAGE_IDX_W = left_shift_unit_pkg::STAGE_IDX_W
) (
  input  logic [XLEN-1:0]        acc_i,
  input  logic [STAGE_IDX_W-1:0] stage_i,
  input  logic                   en_i,
  input  logic                   rotate_i,
  output logic [XLEN-1:0]        acc_o
);

  logic [SHAMT_W-1:0] amt;
  logic [XLEN-1:0]    shl;
  logic [XLEN-1:0]    rotl;

  always_comb begin
    amt  = SHAMT_W'(1) << stage_i;
    shl  = acc_i << amt;
    // amt is never 0 here, so the right-shift distance stays below XLEN.
    rotl = shl | (acc_i >> (XLEN - 32'(amt)));
    if (!en_i) begin
      acc_o = acc_i;
    end else if (rotate_i) begin
      acc_o = rotl;
    end else begin
      acc_o = shl;
    end
  end

endmodule

// File: rtl/left_shift_unit.sv
// Iterative left shift / rotate unit with valid/ready handshakes.
// An accepted request is processed one shift-amount bit per cycle, from
// bit 4 down to bit 0, so every operation takes exactly 5 SHIFT cycles
// before the result is presented in DONE.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - request handshake (ready only in IDLE)
//   data_in, shamt       - operand and left shift amount
//   rotate               - 1 = rotate left, 0 = logical shift left
//   out_valid / out_ready- result handshake (valid only in DONE)
//   data_out             - result; holds last value until next acceptance
//   busy                 - high whenever not IDLE
module left_shift_unit #(
  parameter int unsigned XLEN    = left_shift_unit_pkg::XLEN,
  parameter int unsigned SHAMT_W = left_shift_unit_pkg::SHAMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               rotate,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    data_out,
  output logic               busy
);

  import left_shift_unit_pkg::*;

  localparam logic [STAGE_IDX_W-1:0] CNT_START = STAGE_IDX_W'(STAGE_CNT - 1);

  state_e                  state_q, state_d;
  logic [XLEN-1:0]         acc_q, acc_d;
  logic [STAGE_IDX_W-1:0]  cnt_q, cnt_d;
  logic [SHAMT_W-1:0]      shamt_q, shamt_d;
  logic                    rot_q, rot_d;
  logic [XLEN-1:0]         stage_acc;

  left_shift_stage #(
    .XLEN        (XLEN),
    .SHAMT_W     (SHAMT_W),
    .STAGE_IDX_W (STAGE_IDX_W)
  ) u_stage (
    .acc_i    (acc_q),
    .stage_i  (cnt_q),
    .en_i     (shamt_q[cnt_q]),
    .rotate_i (rot_q),
    .acc_o    (stage_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      shamt_q <= '0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      shamt_q <= shamt_d;
      rot_q   <= rot_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    shamt_d = shamt_q;
    rot_d   = rot_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          acc_d   = data_in;
          shamt_d = shamt;
          rot_d   = rotate;
          cnt_d   = CNT_START;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d = stage_acc;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign data_out  = acc_q;

endmodule

// File: tb/tb_left_shift_unit.sv
module tb_left_shift_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        rotate;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data_out;
  logic        busy;

  int unsigned checks;
  int unsigned errors;

  left_shift_unit #(
    .XLEN    (32),
    .SHAMT_W (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .shamt     (shamt),
    .rotate    (rotate),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int unsigned s, input logic r);
    logic [31:0] res;
    res = d << s;
    if (r && s != 0) res = res | (d >> (32 - s));
    return res;
  endfunction

  // Accept one request, measure latency to out_valid, check result, drain.
  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                        input logic r, input logic [31:0] exp);
    int unsigned n;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; data_in = d; shamt = s; rotate = r;
    tick();
    in_valid = 1'b0; data_in = '0; shamt = '0; rotate = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd5);
    chk({tag, "_data"}, data_out, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle"}, {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk({tag, "_hold"}, data_out, exp);
  endtask

  initial begin
    logic [31:0] d, exp_v, held;
    logic [4:0]  s;
    logic        r;
    int unsigned n, results;

    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; data_in = '0; shamt = '0; rotate = 1'b0; out_ready = 1'b0;
    #12;
    chk("reset_outputs", {28'd0, in_ready, out_valid, busy, 1'b0}, 32'b1000);
    chk("reset_data", data_out, 32'h0);
    rst_n = 1'b1;
    tick();

    run_op("shl31",    32'h0000_0001, 5'd31, 1'b0, 32'h8000_0000);
    run_op("rotl1",    32'h8000_0001, 5'd1,  1'b1, 32'h0000_0003);
    run_op("shl1",     32'h8000_0001, 5'd1,  1'b0, 32'h0000_0002);
    run_op("shamt0",   32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF);
    run_op("rotl16",   32'hDEAD_BEEF, 5'd16, 1'b1, 32'hBEEF_DEAD);
    run_op("rotl31",   32'h0000_0003, 5'd31, 1'b1, 32'h8000_0001);
    run_op("shl_mix",  32'h1234_5678, 5'd12, 1'b0, 32'h4567_8000);

    // Backpressure in DONE with a competing request.
    in_valid = 1'b1; data_in = 32'h0000_00FF; shamt = 5'd8; rotate = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("bp_enter_done", 32'(out_valid), 32'd1);
    in_valid = 1'b1; data_in = 32'hFFFF_FFFF; shamt = 5'd3; rotate = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_flags", {29'd0, out_valid, in_ready, busy}, 32'b101);
      chk("bp_data", data_out, 32'h0000_FF00);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("bp_hold", data_out, 32'h0000_FF00);

    // Reset during the third SHIFT cycle.
    in_valid = 1'b1; data_in = 32'hDEAD_BEEF; shamt = 5'd5; rotate = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("midrst_data", data_out, 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    n = 0;
    while (n < 8) begin
      chk("midrst_no_result", 32'(out_valid), 32'd0);
      tick();
      n += 4;
    end
    run_op("after_rst", 32'h0000_00F0, 5'd4, 1'b0, 32'h0000_0F00);

    // Random operations with random output backpressure.
    results = 0;
    for (int i = 0; i < 1000; i++) begin
      d = $urandom;
      s = 5'($urandom_range(0, 31));
      r = 1'($urandom_range(0, 1));
      exp_v = ref_shift(d, s, r);
      in_valid = 1'b1; data_in = d; shamt = s; rotate = r;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
      if (n != 5) chk("rand_latency", n, 32'd5);
      if (data_out !== exp_v) chk("rand_data", data_out, exp_v);
      else checks++;
      held = data_out;
      n = 0;
      do begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
        if (out_ready === 1'b0 && (out_valid !== 1'b1 || data_out !== held))
          chk("rand_bp_stable", data_out, held);
      end while (out_ready !== 1'b1 && n < 50);
      out_ready = 1'b0;
      if (out_valid === 1'b1) chk("rand_drain", 32'(out_valid), 32'd0);
      else results++;
    end
    chk("rand_result_count", results, 32'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
